// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore-style main controller for the multi-cycle RV32I core. It walks each
// instruction through fetch, decode, address/ALU execute, memory access and
// writeback (3 to 5 cycles). It drives the shared datapath mux selects, the
// register/memory write enables and the immediate format select. It also
// parks in a sticky fault state on unsupported opcodes and counts retired
// instructions.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst_n        synchronous active-low reset
//   op           Instr[6:0] from the instruction register
//   funct3       Instr[14:12]
//   funct7b5     Instr[30]
//   zero         ALU zero flag, used by beq/bne
//   pc_write     PC register enable
//   adr_src      memory address select (0 PC, 1 ALUOut)
//   mem_write    data memory write enable
//   ir_write     instruction/oldPC register enable
//   reg_write    register file write enable
//   result_src   result mux select (00 ALUOut, 01 Data, 10 ALUResult)
//   alu_src_a    ALU A select (00 PC, 01 oldPC, 10 rs1)
//   alu_src_b    ALU B select (00 rs2, 01 ImmExt, 10 constant 4)
//   alu_control  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src      immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal      high while parked in the fault state
//   retire       one-cycle pulse on the last cycle of each instruction
//   retired_cnt  wrapping count of retired instructions
//   state        current state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;

    // State register; reset always returns to FETCH so any half-done
    // instruction is simply abandoned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. FAULT is absorbing until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BRNCH:          state_d = BRANCH;
                    default:           state_d = FAULT;
                endcase
            end
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECR, EXECI, JAL: state_d = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BRANCH: state_d = FETCH;
            FAULT:    state_d = FAULT;
            default:  state_d = FAULT;
        endcase
    end

    // Moore outputs per state. The branch PC enable is the one exception:
    // it depends combinationally on zero/funct3 so the branch resolves in
    // the single BRANCH cycle.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        retire        = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                retire        = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            JAL: begin
                pc_write_raw = 1'b1;
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                retire    = 1'b1;
                case (funct3)
                    3'b000:  pc_write_raw = zero;
                    3'b001:  pc_write_raw = ~zero;
                    default: pc_write_raw = 1'b0;
                endcase
            end
            default: begin
            end
        endcase
    end

    // Write enables are gated by reset so nothing is written while it is held.
    assign pc_write  = pc_write_raw  & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign mem_write = mem_write_raw & rst_n;

    // ALU decoder. Only R-type (op[5]=1) with funct7b5 set selects sub;
    // addi never subtracts even when its immediate has bit 30 set.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format follows the opcode alone, regardless of state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BRNCH: imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

    assign illegal = (state_q == FAULT);
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. A vector table holds one record
// per clock cycle: the inputs for that cycle and the expected state, PC
// enable, ALU control and retire pulse. The remaining Moore outputs come from
// a per-state table written from the controller's output list. Each applied
// vector is pushed to a scoreboard queue and popped when the outputs are
// sampled mid-cycle. A second instance with a 4-bit counter shares the
// stimulus so counter wrap can be seen.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] BR = 7'b1100011;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_AND = 3'b010;
    localparam logic [2:0] C_OR  = 3'b011;
    localparam logic [2:0] C_SLT = 3'b101;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [3:0] st;
        logic       pcw;
        logic [2:0] aluc;
        logic       ret;
    } vec_t;

    typedef struct packed {
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       ill;
    } row_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;

    logic        pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        illegal, retire;
    logic [31:0] retired_cnt;
    logic [3:0]  state;

    logic        pc_write4, adr_src4, mem_write4, ir_write4, reg_write4;
    logic [1:0]  result_src4, alu_src_a4, alu_src_b4, imm_src4;
    logic [2:0]  alu_control4;
    logic        illegal4, retire4;
    logic [3:0]  retired_cnt4;
    logic [3:0]  state4;

    vec_t        vecs[$];
    vec_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;
    logic [31:0] exp_cnt = '0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
        .retire(retire), .retired_cnt(retired_cnt), .state(state)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write4), .adr_src(adr_src4), .mem_write(mem_write4),
        .ir_write(ir_write4), .reg_write(reg_write4),
        .result_src(result_src4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .alu_control(alu_control4),
        .imm_src(imm_src4), .illegal(illegal4), .retire(retire4),
        .retired_cnt(retired_cnt4), .state(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected Moore outputs for each state (PC enable handled per vector).
    function automatic row_t state_row(input logic [3:0] st);
        row_t r;
        r = '0;
        case (st)
            4'd0:  begin r.irw = 1'b1; r.srcb = 2'b10; r.rsrc = 2'b10; end
            4'd1:  begin r.srca = 2'b01; r.srcb = 2'b01; end
            4'd2:  begin r.srca = 2'b10; r.srcb = 2'b01; end
            4'd3:  begin r.adr = 1'b1; end
            4'd4:  begin r.rsrc = 2'b01; r.regw = 1'b1; end
            4'd5:  begin r.adr = 1'b1; r.memw = 1'b1; end
            4'd6:  begin r.srca = 2'b10; end
            4'd7:  begin r.regw = 1'b1; end
            4'd8:  begin r.srca = 2'b10; r.srcb = 2'b01; end
            4'd9:  begin r.srca = 2'b01; r.srcb = 2'b10; end
            4'd10: begin r.srca = 2'b10; end
            4'd15: begin r.ill = 1'b1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BR) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    task automatic addv(input logic r, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic [3:0] st,
                        input logic pcw, input logic [2:0] aluc, input logic ret);
        vec_t v;
        v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.st = st; v.pcw = pcw; v.aluc = aluc; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rst_n;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.z;
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t v;
        row_t r;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        v = sb.pop_front();
        r = state_row(v.st);
        chk("state",       {28'd0, state},       {28'd0, v.st});
        chk("pc_write",    {31'd0, pc_write},    {31'd0, v.pcw & v.rst_n});
        chk("adr_src",     {31'd0, adr_src},     {31'd0, r.adr});
        chk("mem_write",   {31'd0, mem_write},   {31'd0, r.memw & v.rst_n});
        chk("ir_write",    {31'd0, ir_write},    {31'd0, r.irw & v.rst_n});
        chk("reg_write",   {31'd0, reg_write},   {31'd0, r.regw & v.rst_n});
        chk("result_src",  {30'd0, result_src},  {30'd0, r.rsrc});
        chk("alu_src_a",   {30'd0, alu_src_a},   {30'd0, r.srca});
        chk("alu_src_b",   {30'd0, alu_src_b},   {30'd0, r.srcb});
        chk("alu_control", {29'd0, alu_control}, {29'd0, v.aluc});
        chk("imm_src",     {30'd0, imm_src},     {30'd0, exp_imm(v.op)});
        chk("illegal",     {31'd0, illegal},     {31'd0, r.ill});
        chk("retire",      {31'd0, retire},      {31'd0, v.ret});
        chk("retired_cnt", retired_cnt,          exp_cnt);
        chk("retired_cnt4", {28'd0, retired_cnt4}, {28'd0, exp_cnt[3:0]});
        chk("state4",      {28'd0, state4},      {28'd0, v.st});
        if (!v.rst_n)    exp_cnt = '0;
        else if (v.ret)  exp_cnt = exp_cnt + 1;
    endtask

    initial begin
        rst_n = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;

        // Reset held for two sampled cycles
        addv(0, LW, 3'b010, 0, 0, 4'd0, 0, C_ADD, 0);
        addv(0, LW, 3'b010, 0, 0, 4'd0, 0, C_ADD, 0);
        // lw: 5 cycles
        addv(1, LW, 3'b010, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd2, 0, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd3, 0, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd4, 0, C_ADD, 1);
        // sw: 4 cycles
        addv(1, SW, 3'b010, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, SW, 3'b010, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, SW, 3'b010, 0, 0, 4'd2, 0, C_ADD, 0);
        addv(1, SW, 3'b010, 0, 0, 4'd5, 0, C_ADD, 1);
        // add
        addv(1, RT, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd6, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd7, 0, C_ADD, 1);
        // sub
        addv(1, RT, 3'b000, 1, 0, 4'd0, 1, C_ADD, 0);
        addv(1, RT, 3'b000, 1, 0, 4'd1, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 1, 0, 4'd6, 0, C_SUB, 0);
        addv(1, RT, 3'b000, 1, 0, 4'd7, 0, C_ADD, 1);
        // and (R-type)
        addv(1, RT, 3'b111, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, RT, 3'b111, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, RT, 3'b111, 0, 0, 4'd6, 0, C_AND, 0);
        addv(1, RT, 3'b111, 0, 0, 4'd7, 0, C_ADD, 1);
        // addi with bit 30 set still adds
        addv(1, IT, 3'b000, 1, 0, 4'd0, 1, C_ADD, 0);
        addv(1, IT, 3'b000, 1, 0, 4'd1, 0, C_ADD, 0);
        addv(1, IT, 3'b000, 1, 0, 4'd8, 0, C_ADD, 0);
        addv(1, IT, 3'b000, 1, 0, 4'd7, 0, C_ADD, 1);
        // slti
        addv(1, IT, 3'b010, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, IT, 3'b010, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, IT, 3'b010, 0, 0, 4'd8, 0, C_SLT, 0);
        addv(1, IT, 3'b010, 0, 0, 4'd7, 0, C_ADD, 1);
        // ori
        addv(1, IT, 3'b110, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, IT, 3'b110, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, IT, 3'b110, 0, 0, 4'd8, 0, C_OR,  0);
        addv(1, IT, 3'b110, 0, 0, 4'd7, 0, C_ADD, 1);
        // beq taken
        addv(1, BR, 3'b000, 0, 1, 4'd0, 1, C_ADD, 0);
        addv(1, BR, 3'b000, 0, 1, 4'd1, 0, C_ADD, 0);
        addv(1, BR, 3'b000, 0, 1, 4'd10, 1, C_SUB, 1);
        // beq not taken
        addv(1, BR, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, BR, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, BR, 3'b000, 0, 0, 4'd10, 0, C_SUB, 1);
        // bne taken
        addv(1, BR, 3'b001, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, BR, 3'b001, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, BR, 3'b001, 0, 0, 4'd10, 1, C_SUB, 1);
        // bne not taken
        addv(1, BR, 3'b001, 0, 1, 4'd0, 1, C_ADD, 0);
        addv(1, BR, 3'b001, 0, 1, 4'd1, 0, C_ADD, 0);
        addv(1, BR, 3'b001, 0, 1, 4'd10, 0, C_SUB, 1);
        // unsupported branch funct3 never writes the PC
        addv(1, BR, 3'b100, 0, 1, 4'd0, 1, C_ADD, 0);
        addv(1, BR, 3'b100, 0, 1, 4'd1, 0, C_ADD, 0);
        addv(1, BR, 3'b100, 0, 1, 4'd10, 0, C_SUB, 1);
        // jal
        addv(1, JL, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, JL, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, JL, 3'b000, 0, 0, 4'd9, 1, C_ADD, 0);
        addv(1, JL, 3'b000, 0, 0, 4'd7, 0, C_ADD, 1);

        // Hand-written: reset held 3 cycles starting mid-EXECR
        addv(1, RT, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(0, RT, 3'b000, 0, 0, 4'd6, 0, C_ADD, 0);
        addv(0, RT, 3'b000, 0, 0, 4'd0, 0, C_ADD, 0);
        addv(0, RT, 3'b000, 0, 0, 4'd0, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd6, 0, C_ADD, 0);
        addv(1, RT, 3'b000, 0, 0, 4'd7, 0, C_ADD, 1);

        // Hand-written: 15 more retires make 16 since reset, so the 4-bit
        // counter passes 15 and wraps to 0
        for (int k = 0; k < 15; k++) begin
            addv(1, BR, 3'b000, 0, 1, 4'd0, 1, C_ADD, 0);
            addv(1, BR, 3'b000, 0, 1, 4'd1, 0, C_ADD, 0);
            addv(1, BR, 3'b000, 0, 1, 4'd10, 1, C_SUB, 1);
        end

        // Hand-written: illegal opcode parks in FAULT, ignores op changes,
        // and only reset gets it out
        addv(1, 7'b0000000, 3'b000, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, 7'b0000000, 3'b000, 0, 0, 4'd1, 0, C_ADD, 0);
        for (int k = 0; k < 10; k++) begin
            addv(1, (k % 2 == 0) ? LW : SW, 3'b000, 0, 1, 4'd15, 0, C_ADD, 0);
        end
        addv(0, LW, 3'b010, 0, 0, 4'd15, 0, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd0, 1, C_ADD, 0);
        addv(1, LW, 3'b010, 0, 0, 4'd1, 0, C_ADD, 0);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cycle = i;
            applyStimulus(vecs[i]);
            #2;
            checkOutput();
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main controller for the multi-cycle variant of the RV32I core. It sequences instruction fetch, decode, address and ALU execute, memory access and writeback over 3–5 cycles per instruction. It drives the shared ALU/memory mux selects, the write enables and the immediate-extender format select `imm_src`. It also flags illegal opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `op`  in  7  `Instr[6:0]` from the instruction register.
- `funct3`  in  3  `Instr[14:12]`.
- `funct7b5`  in  1  `Instr[30]`.
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  data memory write enable.
- `ir_write`  out  1  instruction/oldPC register enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  00 = PC, 01 = oldPC, 10 = rs1 data.
- `alu_src_b`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- `illegal`  out  1  sticky unsupported-opcode flag.
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction.
- `retired_cnt`  out  CNT_W  count of retired instructions.
- `state`  out  4  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, FAULT=15.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1101111 → JAL.
    - 1100011 → BRANCH.
    - anything else → FAULT.
  - MEMADR → MEMREAD if `op[5]`=0, else → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
  - FAULT → FAULT until reset.
- Per-state outputs (anything not listed is 0; an unlisted `alu_op` is 00):
  - FETCH: `ir_write`=1, `pc_write`=1, `alu_src_b`=10, `result_src`=10, `alu_op`=00.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (precomputes the branch/jump target).
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - MEMREAD: `adr_src`=1.
  - MEMWB: `result_src`=01, `reg_write`=1.
  - MEMWRITE: `adr_src`=1, `mem_write`=1.
  - EXECR: `alu_src_a`=10, `alu_op`=10.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10.
  - ALUWB: `reg_write`=1.
  - JAL: `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00.
  - BRANCH: `alu_src_a`=10, `alu_op`=01. `pc_write` = `zero` when `funct3`=000 (beq), ~`zero` when `funct3`=001 (bne), 0 for any other `funct3`.
- `alu_control` is decoded from the internal `alu_op`:
  - `alu_op`=00 → add; 01 → sub.
  - `alu_op`=10, by `funct3`:
    - 000 → sub if `op[5]` & `funct7b5`, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - any other value → add.
- `imm_src` is a combinational decode of `op`, independent of state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - anything else → 00.
- `illegal` is 1 exactly when the state is FAULT. In FAULT every write enable is 0.
- `retire` = 1 in MEMWB, MEMWRITE, ALUWB and BRANCH (taken or not). `retired_cnt` increments by 1 on each cycle with `retire`=1 and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: while `rst_n`=0 at a clock edge, the state becomes FETCH and `retired_cnt` becomes 0.
  - While `rst_n` is low, `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced to 0.
  - `retire` and `illegal` read 0 after that edge.
  - Reset asserted in any state, including mid-instruction or FAULT, aborts the instruction with no further writes.
- The first FETCH is the cycle after `rst_n` is sampled high.
- State-derived outputs are Moore outputs, valid throughout the state. `alu_control`, `imm_src` and BRANCH `pc_write` are combinational from the inputs, with zero added latency.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq/bne 3.
- `op`/`funct` must hold stable from DECODE through the instruction's last state; `ir_write` is asserted only in FETCH.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles mid-EXECR → `state`=0, all write enables 0, `retired_cnt`=0; FETCH with `ir_write`=`pc_write`=1 on the first cycle after release.
- lw (`op`=0000011) → states 0,1,2,3,4; `adr_src`=1 in MEMREAD; `reg_write`=1 and `result_src`=01 in MEMWB; `retire` only in MEMWB; `imm_src`=00.
- sw then add then sub (`funct7b5`=1) → sw: states 0,1,2,5, `mem_write`=1 in state 5 only, `imm_src`=01. R-types: `alu_control` 000 then 001 in EXECR; `retired_cnt` rises by 3.
- beq with `zero`=1, then `zero`=0, then bne with `zero`=0 → `pc_write`=1, 0, 1 in BRANCH; each instruction 3 cycles; `imm_src`=10.
- jal → states 0,1,9,7; `pc_write`=1 in JAL; `reg_write`=1 in ALUWB; `imm_src`=11.
- Illegal `op`=0000000 → FAULT from the cycle after DECODE; `illegal`=1 and held with no writes for 10 cycles; cleared by reset. Separately, preload `CNT_W`=4 and retire 16 instructions → `retired_cnt` wraps to 0.
